reg_file: RTL and testbench



---
 rtl/reg_file.sv | 46 ++++
 tb/tb_reg_file.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit register file, two combinational read ports, one synchronous write port.
// Ports: clock, reset_n (async active-low clear of all entries),
//        RegWrite/WriteRegister/WriteData (write-back port),
//        ReadRegister_1/2 -> ReadData_1/2 (decode-stage read ports).
// Register 0 is hardwired to zero; out-of-range writes are ignored and reads return 0.
// Optional: define REGFILE_BYPASS_EN for write-through bypass of same-cycle writes to the read ports.
module reg_file #(
  parameter int size       = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadRegister_1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister_2,
  output logic [DATA_WIDTH-1:0] ReadData_1,
  output logic [DATA_WIDTH-1:0] ReadData_2
);
  logic [DATA_WIDTH-1:0] Data_register [size];
  logic                  we;
  logic                  hit_1, hit_2;
  assign we = RegWrite && (WriteRegister != '0) && (int'(WriteRegister) < size);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < size; i++) Data_register[i] <= '0;
    end else if (we) begin
      Data_register[WriteRegister] <= WriteData;
    end
  end
`ifdef REGFILE_BYPASS_EN
  // we already excludes index 0, so register 0 is never bypassed
  assign hit_1 = we && (ReadRegister_1 == WriteRegister);
  assign hit_2 = we && (ReadRegister_2 == WriteRegister);
`else
  assign hit_1 = 1'b0;
  assign hit_2 = 1'b0;
`endif
  // reads are forced to 0 during reset so a bypassed write cannot leak through
  assign ReadData_1 = !reset_n ? '0 : hit_1 ? WriteData :
                      (int'(ReadRegister_1) < size) ? Data_register[ReadRegister_1] : '0;
  assign ReadData_2 = !reset_n ? '0 : hit_2 ? WriteData :
                      (int'(ReadRegister_2) < size) ? Data_register[ReadRegister_2] : '0;
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file (table vectors, scoreboard queue, corner sequences).
module tb_reg_file;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister_1, ReadRegister_2;
  logic [31:0] ReadData_1, ReadData_2;

  reg_file dut (
    .clock(clock), .reset_n(reset_n), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister_1(ReadRegister_1), .ReadRegister_2(ReadRegister_2),
    .ReadData_1(ReadData_1), .ReadData_2(ReadData_2)
  );

  always #10 clock = ~clock;

  typedef struct {
    bit          rw;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1, r2;
    logic [31:0] e1, e2;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] e1, e2;
  } exp_t;

  vec_t        vecs [7];
  exp_t        sb_q [$];
  logic [31:0] mdl [32];
  int          checks = 0;
  int          errors = 0;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit rw, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    RegWrite = rw; WriteRegister = wa; WriteData = wd;
    ReadRegister_1 = r1; ReadRegister_2 = r2;
  endtask

  task automatic push(input string name, input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    e.name = name; e.e1 = e1; e.e2 = e2;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got no entry expected one");
    end else begin
      e = sb_q.pop_front();
      chk({e.name, "_rd1"}, ReadData_1, e.e1);
      chk({e.name, "_rd2"}, ReadData_2, e.e2);
    end
  endtask

  function automatic logic [31:0] pre_exp(input bit rw, input logic [4:0] wa,
                                          input logic [31:0] wd, input logic [4:0] r);
    return (BYPASS && rw && wa != 0 && r == wa) ? wd : mdl[r];
  endfunction

  initial begin
    vecs[0] = '{1, 5'd11, 32'h0000FFFF, 5'd11, 5'd22, 32'h0000FFFF, 32'h0};
    vecs[1] = '{1, 5'd22, 32'h0000EEEE, 5'd11, 5'd22, 32'h0000FFFF, 32'h0000EEEE};
    vecs[2] = '{0, 5'd5,  32'h12345678, 5'd5,  5'd22, 32'h0,        32'h0000EEEE};
    vecs[3] = '{1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd31, 32'h0,        32'h0};
    vecs[4] = '{0, 5'd11, 32'h0,        5'd11, 5'd11, 32'h0000FFFF, 32'h0000FFFF};
    vecs[5] = '{1, 5'd31, 32'h80000001, 5'd31, 5'd0,  32'h80000001, 32'h0};
    vecs[6] = '{1, 5'd7,  32'h00000001, 5'd7,  5'd11, 32'h00000001, 32'h0000FFFF};
    for (int i = 0; i < 32; i++) mdl[i] = '0;

    reset_n = 1'b1;
    drive(0, 5'd0, 32'h0, 5'd1, 5'd2);
    #15 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) chk($sformatf("reset_entry_%0d", i), dut.Data_register[i], 32'h0);
    push("reset_read", 32'h0, 32'h0);
    pop_cmp();
    #9 reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].rw, vecs[i].wa, vecs[i].wd, vecs[i].r1, vecs[i].r2);
      push($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2);
      if (vecs[i].rw && vecs[i].wa != 0) mdl[vecs[i].wa] = vecs[i].wd;
      @(posedge clock); #1;
      pop_cmp();
    end
    for (int i = 0; i < 32; i++) chk($sformatf("dump_entry_%0d", i), dut.Data_register[i], mdl[i]);

    @(negedge clock);
    drive(1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd0);
    #1 push("same_cycle_pre", BYPASS ? 32'hA5A5A5A5 : 32'h1, 32'h0);
    pop_cmp();
    @(posedge clock); #1;
    push("same_cycle_post", 32'hA5A5A5A5, 32'h0);
    pop_cmp();
    mdl[7] = 32'hA5A5A5A5;

    @(negedge clock);
    drive(1, 5'd0, 32'h55555555, 5'd0, 5'd7);
    #1 push("zero_no_bypass", 32'h0, 32'hA5A5A5A5);
    pop_cmp();

    @(negedge clock);
    drive(0, 5'd5, 32'h12345678, 5'd5, 5'd5);
    repeat (3) @(posedge clock);
    #1 chk("we_low_entry5", dut.Data_register[5], 32'h0);
    chk("zero_entry0", dut.Data_register[0], 32'h0);

    for (int n = 0; n < 24; n++) begin
      bit          rw;
      logic [4:0]  wa, r1, r2;
      logic [31:0] wd;
      @(negedge clock);
      rw = 1'($urandom_range(0, 1)); wa = 5'($urandom); wd = $urandom;
      r1 = (n % 2 == 0) ? wa : 5'($urandom); r2 = 5'($urandom);
      drive(rw, wa, wd, r1, r2);
      #1 push($sformatf("rand%0d_pre", n), pre_exp(rw, wa, wd, r1), pre_exp(rw, wa, wd, r2));
      pop_cmp();
      if (rw && wa != 0) mdl[wa] = wd;
      @(posedge clock); #1;
      push($sformatf("rand%0d_post", n), mdl[r1], mdl[r2]);
      pop_cmp();
    end

    @(negedge clock);
    drive(1, 5'd11, 32'h0000FFFF, 5'd11, 5'd11);
    @(posedge clock);
    @(negedge clock);
    drive(0, 5'd0, 32'h0, 5'd11, 5'd11);
    #1 chk("mid_before_reset", ReadData_1, 32'h0000FFFF);
    #2 reset_n = 1'b0;
    #1 chk("mid_reset_rd1", ReadData_1, 32'h0);
    chk("mid_reset_entry11", dut.Data_register[11], 32'h0);
    drive(1, 5'd11, 32'h00001234, 5'd11, 5'd11);
    #1 chk("reset_write_bypass_rd2", ReadData_2, 32'h0);
    @(posedge clock); #1;
    chk("reset_write_discarded", dut.Data_register[11], 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(0, 5'd0, 32'h0, 5'd11, 5'd3);
    @(posedge clock); #1;
    push("after_reset", 32'h0, 32'h0);
    pop_cmp();
    @(negedge clock);
    drive(1, 5'd3, 32'h00000033, 5'd11, 5'd3);
    @(posedge clock); #1;
    push("after_reset_write", 32'h0, 32'h00000033);
    pop_cmp();

    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
